// File: rtl/mem_stage.sv
// Memory stage: EX/MM and MM/WB pipeline registers plus a word load/store
// engine over a variable-latency req/ack port with a bounded wait.
module mem_stage #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [31:0] LD_ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        busy_ex,
    input  logic [1:0]  MM_in,
    input  logic [3:0]  WB_in,
    input  logic [4:0]  dst_in,
    input  logic        result_P,
    input  logic [31:0] result_I,
    input  logic [31:0] result_F,
    input  logic [31:0] Wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_mm,
    output logic        mem_err,
    output logic        pval_mm,
    output logic [31:0] rval_mm,
    output logic [31:0] fval_mm,
    output logic [3:0]  WB_mm,
    output logic [4:0]  dst_mm,
    output logic [3:0]  WB_wb,
    output logic [4:0]  dst_wb,
    output logic        pval_wb,
    output logic [31:0] rval_wb,
    output logic [31:0] fval_wb
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // EX/MM register
    logic [1:0]  mm_q, mm_d;
    logic [3:0]  wb_q, wb_d;
    logic [4:0]  dst_q, dst_d;
    logic        p_q, p_d;
    logic [31:0] i_q, i_d;
    logic [31:0] f_q, f_d;
    logic [31:0] wdata_q, wdata_d;

    // MM/WB register
    logic [3:0]  wbwb_q, wbwb_d;
    logic [4:0]  dstwb_q, dstwb_d;
    logic        pwb_q, pwb_d;
    logic [31:0] rwb_q, rwb_d;
    logic [31:0] fwb_q, fwb_d;

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        active;
    logic        timeout_hit;
    logic        complete;
    logic [31:0] ld_data;

    assign active      = (mm_q == 2'b01) || (mm_q == 2'b10);
    assign timeout_hit = active && (state_q == ST_WAIT) && !mem_ack && (cnt_q == CNT_LAST);
    assign complete    = active && (mem_ack || timeout_hit);
    // An ack with no request outstanding must never leak into the load mux.
    assign ld_data     = (active && mem_ack) ? mem_rdata : LD_ERR_DATA;

    assign stall_mm  = active && !complete;
    assign mem_req   = active;
    assign mem_we    = (mm_q == 2'b10);
    assign mem_addr  = i_q;
    assign mem_wdata = wdata_q;
    assign mem_err   = timeout_hit;

    assign pval_mm = p_q;
    assign rval_mm = i_q;
    assign fval_mm = f_q;
    assign WB_mm   = wb_q;
    assign dst_mm  = dst_q;

    assign WB_wb   = wbwb_q;
    assign dst_wb  = dstwb_q;
    assign pval_wb = pwb_q;
    assign rval_wb = rwb_q;
    assign fval_wb = fwb_q;

    always_comb begin
        mm_d    = mm_q;
        wb_d    = wb_q;
        dst_d   = dst_q;
        p_d     = p_q;
        i_d     = i_q;
        f_d     = f_q;
        wdata_d = wdata_q;
        if (!stall_mm) begin
            if (busy_ex) begin
                mm_d    = 2'b00;
                wb_d    = 4'b0000;
                dst_d   = 5'd0;
                p_d     = 1'b0;
                i_d     = 32'd0;
                f_d     = 32'd0;
                wdata_d = 32'd0;
            end else begin
                mm_d    = MM_in;
                wb_d    = WB_in;
                dst_d   = dst_in;
                p_d     = result_P;
                i_d     = result_I;
                f_d     = result_F;
                wdata_d = Wdata;
            end
        end
    end

    always_comb begin
        wbwb_d  = 4'b0000;
        dstwb_d = 5'd0;
        pwb_d   = 1'b0;
        rwb_d   = 32'd0;
        fwb_d   = 32'd0;
        if (!stall_mm) begin
            wbwb_d  = wb_q;
            dstwb_d = dst_q;
            pwb_d   = p_q;
            rwb_d   = wb_q[3] ? ld_data : i_q;
            fwb_d   = wb_q[3] ? ld_data : f_q;
        end
    end

    // The counter holds the number of request cycles already spent in the access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (active && !mem_ack) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            ST_WAIT: begin
                if (complete || !active) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_q    <= 2'b00;
            wb_q    <= 4'b0000;
            dst_q   <= 5'd0;
            p_q     <= 1'b0;
            i_q     <= 32'd0;
            f_q     <= 32'd0;
            wdata_q <= 32'd0;
            wbwb_q  <= 4'b0000;
            dstwb_q <= 5'd0;
            pwb_q   <= 1'b0;
            rwb_q   <= 32'd0;
            fwb_q   <= 32'd0;
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            mm_q    <= mm_d;
            wb_q    <= wb_d;
            dst_q   <= dst_d;
            p_q     <= p_d;
            i_q     <= i_d;
            f_q     <= f_d;
            wdata_q <= wdata_d;
            wbwb_q  <= wbwb_d;
            dstwb_q <= dstwb_d;
            pwb_q   <= pwb_d;
            rwb_q   <= rwb_d;
            fwb_q   <= fwb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table driven through EX, a behavioural memory
// responder, and a scoreboard of expected MM/WB results.
module tb_mem_stage;
    localparam int TO = 16;
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy_ex;
    logic [1:0]  MM_in;
    logic [3:0]  WB_in;
    logic [4:0]  dst_in;
    logic        result_P;
    logic [31:0] result_I, result_F, Wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_mm, mem_err;
    logic        pval_mm;
    logic [31:0] rval_mm, fval_mm;
    logic [3:0]  WB_mm;
    logic [4:0]  dst_mm;
    logic [3:0]  WB_wb;
    logic [4:0]  dst_wb;
    logic        pval_wb;
    logic [31:0] rval_wb, fval_wb;

    mem_stage #(.TIMEOUT(TO), .LD_ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rst(rst), .busy_ex(busy_ex), .MM_in(MM_in), .WB_in(WB_in),
        .dst_in(dst_in), .result_P(result_P), .result_I(result_I),
        .result_F(result_F), .Wdata(Wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall_mm(stall_mm), .mem_err(mem_err),
        .pval_mm(pval_mm), .rval_mm(rval_mm), .fval_mm(fval_mm), .WB_mm(WB_mm),
        .dst_mm(dst_mm), .WB_wb(WB_wb), .dst_wb(dst_wb), .pval_wb(pval_wb),
        .rval_wb(rval_wb), .fval_wb(fval_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [1:0]  mm;
        logic [3:0]  wb;
        logic [4:0]  dst;
        logic        p;
        logic [31:0] i;
        logic [31:0] f;
        logic [31:0] wdata;
        int          delay;   // ack on request cycle delay+1; >= TO means never
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [3:0]  wb;
        logic [4:0]  dst;
        logic        p;
        logic [31:0] r;
        logic [31:0] f;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } memop_t;

    localparam int NV = 12;
    vec_t   vec [NV];
    exp_t   sb_q [$];
    memop_t mop_q [$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(logic busy, logic [1:0] mm, logic [3:0] wb, logic [4:0] dst,
                                logic p, logic [31:0] i, logic [31:0] f, logic [31:0] wd,
                                int delay, logic [31:0] rd);
        vec_t v;
        v.busy = busy; v.mm = mm; v.wb = wb; v.dst = dst; v.p = p;
        v.i = i; v.f = f; v.wdata = wd; v.delay = delay; v.rdata = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        busy_ex = 1'b1; MM_in = 2'b00; WB_in = 4'b0000; dst_in = 5'd0;
        result_P = 1'b0; result_I = 32'd0; result_F = 32'd0; Wdata = 32'd0;
    endtask

    initial begin
        int     v;
        int     cycles;
        int     req_cnt;
        int     stall_cnt;
        logic   prev_valid;
        vec_t   prev;
        exp_t   e;
        exp_t   got;
        memop_t m;
        logic   exp_err;

        // {busy, mm, wb, dst, p, result_I, result_F, Wdata, ack delay, rdata}
        vec[0]  = mk(0, 2'b00, 4'b0010, 5'd3,  0, 32'h0000_0010, 32'h0000_0011, 32'h0,         0,   32'h0);
        vec[1]  = mk(0, 2'b01, 4'b1010, 5'd5,  0, 32'h0000_0100, 32'h0,         32'h0,         0,   32'hCAFE_F00D);
        vec[2]  = mk(0, 2'b10, 4'b0000, 5'd0,  0, 32'h0000_0200, 32'h0,         32'h1234_5678, 3,   32'h0);
        vec[3]  = mk(0, 2'b00, 4'b0101, 5'd9,  1, 32'h0000_0044, 32'h3F80_0000, 32'h0,         0,   32'h0);
        vec[4]  = mk(0, 2'b01, 4'b1010, 5'd7,  0, 32'h0000_0300, 32'h0,         32'h0,         255, 32'h0);
        vec[5]  = mk(1, 2'b01, 4'b0111, 5'd12, 1, 32'hAAAA_0001, 32'hBBBB_0001, 32'h1,         0,   32'h0);
        vec[6]  = mk(1, 2'b10, 4'b0111, 5'd13, 1, 32'hAAAA_0002, 32'hBBBB_0002, 32'h2,         0,   32'h0);
        vec[7]  = mk(0, 2'b01, 4'b1100, 5'd17, 0, 32'h0000_0400, 32'h4000_0000, 32'h0,         1,   32'hDEAD_BEEF);
        vec[8]  = mk(0, 2'b10, 4'b0000, 5'd0,  0, 32'h0000_0500, 32'h0,         32'h0BAD_CAFE, 0,   32'h0);
        vec[9]  = mk(0, 2'b01, 4'b1010, 5'd21, 0, 32'h0000_0600, 32'h0,         32'h0,         2,   32'h55AA_55AA);
        vec[10] = mk(0, 2'b00, 4'b0011, 5'd31, 1, 32'hFFFF_FFFF, 32'h0,         32'h0,         0,   32'h0);
        vec[11] = mk(0, 2'b11, 4'b0010, 5'd1,  0, 32'h0000_0077, 32'h0,         32'h0,         0,   32'h0);

        rst = 1'b1;
        drive_idle();
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs",
              {mem_req, mem_we, stall_mm, mem_err, pval_mm, rval_mm, fval_mm, WB_mm, dst_mm,
               WB_wb, dst_wb, pval_wb, rval_wb, fval_wb}, '0);

        v = 0; cycles = 0; req_cnt = 0; stall_cnt = 0; prev_valid = 1'b0;
        while ((v < NV || sb_q.size() != 0 || mop_q.size() != 0 || mem_req) && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (prev_valid) begin
                if (prev.busy)
                    check("exmm_bubble", {WB_mm, dst_mm, pval_mm, rval_mm, fval_mm}, '0);
                else
                    check("exmm_latch", {WB_mm, dst_mm, pval_mm, rval_mm, fval_mm},
                          {prev.wb, prev.dst, prev.p, prev.i, prev.f});
            end

            if (mem_req) begin
                if (mop_q.size() == 0) begin
                    check("unexpected_req", 1'b1, 1'b0);
                    mem_ack = 1'b0;
                end else begin
                    m = mop_q[0];
                    req_cnt++;
                    check("mem_port", {mem_we, mem_addr, mem_wdata}, {m.we, m.addr, m.wdata});
                    mem_ack = (req_cnt - 1 == m.delay);
                    mem_rdata = mem_ack ? m.rdata : $urandom;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end

            if (v < NV) begin
                busy_ex = vec[v].busy; MM_in = vec[v].mm; WB_in = vec[v].wb;
                dst_in = vec[v].dst; result_P = vec[v].p; result_I = vec[v].i;
                result_F = vec[v].f; Wdata = vec[v].wdata;
            end else begin
                drive_idle();
            end
            #1;

            exp_err = mem_req && !mem_ack && (req_cnt == TO);
            check("mem_err", mem_err, exp_err);

            if (WB_wb != 4'b0000) begin
                got.wb = WB_wb; got.dst = dst_wb; got.p = pval_wb; got.r = rval_wb; got.f = fval_wb;
                if (sb_q.size() == 0) begin
                    check("unexpected_wb", {got.wb, got.dst}, '0);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn wb=%b dst=%0d p=%0d r=%h f=%h", got.wb, got.dst, got.p, got.r, got.f);
                    check("mmwb", {got.wb, got.dst, got.p, got.r, got.f}, {e.wb, e.dst, e.p, e.r, e.f});
                end
            end

            if (mem_req && !stall_mm && mop_q.size() != 0) begin
                m = mop_q.pop_front();
                check("stall_cycles", stall_cnt, (m.delay < TO) ? m.delay : TO - 1);
                $display("txn mem we=%0d addr=%h req_cycles=%0d", m.we, m.addr, req_cnt);
                req_cnt = 0;
                stall_cnt = 0;
            end else if (stall_mm) begin
                stall_cnt++;
            end

            prev_valid = 1'b0;
            if (!stall_mm && v < NV) begin
                prev = vec[v];
                prev_valid = 1'b1;
                if (!vec[v].busy) begin
                    if (vec[v].mm == 2'b01 || vec[v].mm == 2'b10) begin
                        m.we = (vec[v].mm == 2'b10); m.addr = vec[v].i; m.wdata = vec[v].wdata;
                        m.delay = vec[v].delay; m.rdata = vec[v].rdata;
                        mop_q.push_back(m);
                    end
                    if (vec[v].wb != 4'b0000) begin
                        e.wb = vec[v].wb; e.dst = vec[v].dst; e.p = vec[v].p;
                        if (vec[v].wb[3]) begin
                            e.r = (vec[v].delay < TO) ? vec[v].rdata : ERR_DATA;
                            e.f = e.r;
                        end else begin
                            e.r = vec[v].i;
                            e.f = vec[v].f;
                        end
                        sb_q.push_back(e);
                    end
                end
                v++;
            end
        end
        check("drain_in_budget", cycles < 2000, 1'b1);
        check("scoreboard_empty", sb_q.size(), 0);

        // Reset while a load sits in WAIT.
        @(negedge clk);
        mem_ack = 1'b0;
        busy_ex = 1'b0; MM_in = 2'b01; WB_in = 4'b1010; dst_in = 5'd4; result_I = 32'h0000_0700;
        @(negedge clk);
        drive_idle();
        #1;
        check("rstwait_req", {mem_req, stall_mm}, 2'b11);
        repeat (4) begin
            @(negedge clk);
            #1;
            check("rstwait_noerr", {mem_req, stall_mm, mem_err}, 3'b110);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstwait_after", {mem_req, stall_mm, mem_err, WB_mm, WB_wb}, '0);
        rst = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        #1;
        check("rstwait_idle", {mem_req, stall_mm, mem_err, WB_wb}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
